sub16_div_seq: RTL
==================

# sub16_div_seq

Sequential unsigned 16-bit restoring divider that time-shares a single subtract unit (computed as a + ~b + 1, carry-out = no-borrow) across WIDTH iterations. It is the controller that sequences the subtract datapath in the data pipeline. It accepts one operation per start/done handshake and returns the quotient, the remainder and a divide-by-zero flag.

## Interface
- WIDTH, 16, operand width; iteration count equals WIDTH.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; accepted only in IDLE or DONE.
- dividend  input  WIDTH  unsigned dividend, sampled on accept.
- divisor  input  WIDTH  unsigned divisor, sampled on accept.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- div_zero  output  1  registered; set when the accepted divisor was 0.

## Operation
- One clock (clk). Reset is synchronous and active-low (rst_n).
- States:
  - IDLE: start=1 → RUN, or → DONE if divisor==0.
  - RUN: WIDTH cycles, then → DONE.
  - DONE: lasts one cycle. start=1 → RUN, or → DONE again if divisor==0. Otherwise → IDLE.
- On accept, load internal registers:
  - D ← divisor.
  - R (WIDTH+1 bits) ← 0.
  - Q ← dividend.
  - cnt ← 0.
- Each RUN cycle:
  - {Rs, Qs} = {R, Q} << 1 (Rs is WIDTH+1 bits).
  - trial = Rs − {0, D}, computed with a WIDTH+1-bit subtract; carry-out 1 means no borrow.
  - No borrow: R ← trial, Q ← {Qs[WIDTH-1:1], 1}.
  - Borrow: R ← Rs, Q ← {Qs[WIDTH-1:1], 0}.
  - cnt++.
  - The WIDTH+1-bit remainder path is mandatory; it covers divisors ≥ 2^(WIDTH-1).
- Entering DONE from RUN loads quotient ← Q, remainder ← R[WIDTH-1:0], div_zero ← 0.
- Divide by zero:
  - No iterations are run.
  - Entering DONE loads quotient ← all ones, remainder ← dividend, div_zero ← 1.
- quotient, remainder and div_zero hold their values until the next load into DONE.
- start in RUN is ignored, with no queuing. Operand changes during RUN have no effect.

## Timing
- Cycle 0 is the edge on which start is sampled high in IDLE or DONE.
- Normal operation:
  - busy=1 in cycles 1..WIDTH.
  - done=1 and results valid in cycle WIDTH+1 (cycle 17 for WIDTH=16).
  - busy=0 in that cycle.
- Divide by zero: done=1 in cycle 1. busy never asserts.
- Back-to-back: start high during the done cycle is accepted on that edge. The next busy starts the following cycle. Throughput is one result per WIDTH+1 cycles.
- Reset: rst_n=0 at an edge forces the following, taking priority over start:
  - state=IDLE.
  - busy=0, done=0, div_zero=0.
  - quotient=0, remainder=0, internal registers 0.
- Reset mid-RUN aborts the operation: no done pulse, and outputs are cleared.
- done is never high for two consecutive cycles except under back-to-back divide-by-zero requests.

## Test plan
- Basic divide: reset, then dividend=100, divisor=7, start for 1 cycle.
  - busy high cycles 1–16.
  - done in cycle 17 with quotient=14, remainder=2, div_zero=0.
- Large dividend: 0xFFFF / 0x0001 → quotient=0xFFFF, remainder=0x0000 at cycle 17.
- 17-bit remainder path: 0xFFFF / 0x8001 → quotient=0x0001, remainder=0x7FFE. Also 0x1234 / 0xFFFF → quotient=0, remainder=0x1234.
- Divide by zero: 0x1234 / 0 → done in cycle 1 with div_zero=1, quotient=0xFFFF, remainder=0x1234, busy stays 0.
- Start while busy: start=1 with new operands at cycles 5 and 10 during RUN.
  - Both are ignored; first result unchanged at cycle 17.
  - start held at cycle 17 (the done cycle) is accepted; second done at cycle 34 with the operands sampled at cycle 17.
- Reset mid-operation: rst_n=0 at cycle 8 of a 100/7 run.
  - Next cycle: busy=0, all outputs 0, no done.
  - A fresh 50/5 after release gives quotient=10, remainder=0.

Source files
------------

// File: rtl/sub16_div_seq.sv
// Sequential unsigned restoring divider: one shared WIDTH+1-bit subtractor
// stepped WIDTH times per operation, with a start/done handshake.
module sub16_div_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned SUM_W = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH:0]   r_reg, r_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             busy_next, done_next, div_zero_next;
  logic [WIDTH-1:0] quotient_next, remainder_next;

  logic [WIDTH:0]   rs;
  logic [WIDTH-1:0] qs;
  logic [SUM_W-1:0] sub_sum;
  logic             no_borrow;
  logic [WIDTH:0]   iter_r;
  logic [WIDTH-1:0] iter_q;

  // One restoring step: shift {R,Q} left, trial-subtract D as R + ~D + 1.
  // The extra carry bit above the WIDTH+1-bit sum is the no-borrow flag.
  always_comb begin
    rs        = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    qs        = {q_reg[WIDTH-2:0], 1'b0};
    sub_sum   = {1'b0, rs} + {1'b0, ~{1'b0, d_reg}} + SUM_W'(1);
    no_borrow = sub_sum[WIDTH+1];
    iter_r    = no_borrow ? sub_sum[WIDTH:0] : rs;
    iter_q    = {qs[WIDTH-1:1], no_borrow};
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next     = state;
    d_next         = d_reg;
    q_next         = q_reg;
    r_next         = r_reg;
    cnt_next       = cnt;
    busy_next      = 1'b0;
    done_next      = 1'b0;
    quotient_next  = quotient;
    remainder_next = remainder;
    div_zero_next  = div_zero;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          d_next   = divisor;
          r_next   = '0;
          q_next   = dividend;
          cnt_next = '0;
          if (divisor == '0) begin
            // Divide by zero skips the iterations entirely.
            state_next     = DONE;
            done_next      = 1'b1;
            quotient_next  = '1;
            remainder_next = dividend;
            div_zero_next  = 1'b1;
          end else begin
            state_next = RUN;
            busy_next  = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
      end

      RUN: begin
        r_next   = iter_r;
        q_next   = iter_q;
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_next     = DONE;
          done_next      = 1'b1;
          quotient_next  = iter_q;
          remainder_next = iter_r[WIDTH-1:0];
          div_zero_next  = 1'b0;
        end else begin
          busy_next = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset clears everything and aborts a run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      d_reg     <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      state     <= state_next;
      d_reg     <= d_next;
      q_reg     <= q_next;
      r_reg     <= r_next;
      cnt       <= cnt_next;
      busy      <= busy_next;
      done      <= done_next;
      quotient  <= quotient_next;
      remainder <= remainder_next;
      div_zero  <= div_zero_next;
    end
  end

endmodule
